// File: rtl/traffic_light_ctrl.sv
// Phase sequencer for a two-road intersection with a pedestrian crossing.
// Programs an external delay counter (cnt_len/cnt_rst) and advances on its dn pulse.
module traffic_light_ctrl #(
   parameter logic [31:0] T_GREEN  = 32'd499_999_999,
   parameter logic [31:0] T_YELLOW = 32'd199_999_999,
   parameter logic [31:0] T_ALLRED = 32'd99_999_999,
   parameter logic [31:0] T_WALK   = 32'd699_999_999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dn,
   input  logic        ped_req,
   output logic [31:0] cnt_len,
   output logic        cnt_rst,
   output logic [2:0]  ns_light,
   output logic [2:0]  ew_light,
   output logic        walk,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5,
      WALK = 3'd6
   } state_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   state_e      state_q, state_d;
   logic        cnt_rst_q;
   logic        ped_pend_q, ped_pend_d;
   logic        ret_ew_q, ret_ew_d;
   logic        advance, enter_walk;
   logic [31:0] cnt_len_q;
   logic [2:0]  ns_light_q, ew_light_q;
   logic        walk_q;

   function automatic logic [31:0] len_of(input state_e s);
      case (s)
         NS_G, EW_G: len_of = T_GREEN;
         NS_Y, EW_Y: len_of = T_YELLOW;
         AR1, AR2:   len_of = T_ALLRED;
         WALK:       len_of = T_WALK;
         default:    len_of = T_GREEN;
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input state_e s);
      case (s)
         NS_G:    ns_of = LAMP_G;
         NS_Y:    ns_of = LAMP_Y;
         default: ns_of = LAMP_R;
      endcase
   endfunction

   function automatic logic [2:0] ew_of(input state_e s);
      case (s)
         EW_G:    ew_of = LAMP_G;
         EW_Y:    ew_of = LAMP_Y;
         default: ew_of = LAMP_R;
      endcase
   endfunction

   // A dn seen while the counter is still being restarted belongs to the previous phase.
   assign advance = dn && !cnt_rst_q;

   always_comb begin
      // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         NS_G: if (advance) state_d = NS_Y;
         NS_Y: if (advance) state_d = AR1;
         AR1:  if (advance) state_d = ped_pend_q ? WALK : EW_G;
         EW_G: if (advance) state_d = EW_Y;
         EW_Y: if (advance) state_d = AR2;
         AR2:  if (advance) state_d = ped_pend_q ? WALK : NS_G;
         WALK: if (advance) state_d = ret_ew_q ? EW_G : NS_G;
         default: state_d = NS_G;
      endcase
   end

   // Clearing on WALK entry wins over a request on the same edge.
   assign enter_walk = (state_d == WALK) && (state_q != WALK);
   assign ped_pend_d = enter_walk ? 1'b0 : (ped_pend_q | ped_req);
   assign ret_ew_d   = enter_walk ? (state_q == AR1) : ret_ew_q;

   // Outputs are registered from state_d so lamps change on the same edge as state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= NS_G;
         cnt_rst_q  <= 1'b1;
         ped_pend_q <= 1'b0;
         ret_ew_q   <= 1'b0;
         cnt_len_q  <= T_GREEN;
         ns_light_q <= LAMP_G;
         ew_light_q <= LAMP_R;
         walk_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of state_q.
         state_q    <= state_d;
         cnt_rst_q  <= (state_d != state_q);
         ped_pend_q <= ped_pend_d;
         ret_ew_q   <= ret_ew_d;
         cnt_len_q  <= len_of(state_d);
         ns_light_q <= ns_of(state_d);
         ew_light_q <= ew_of(state_d);
         walk_q     <= (state_d == WALK);
      end
   end

   assign state    = state_q;
   assign cnt_rst  = cnt_rst_q;
   assign cnt_len  = cnt_len_q;
   assign ns_light = ns_light_q;
   assign ew_light = ew_light_q;
   assign walk     = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl; each DUT runs against a behavioural delay counter.
// Instance a: green 4, yellow 2, all-red 1, walk 3. Instance b: same but yellow 0.
module tb_traffic_light_ctrl;

   logic clk;
   logic reset;
   logic ped_req;

   logic [31:0] cnt_len_a, cnt_len_b;
   logic        cnt_rst_a, cnt_rst_b;
   logic [2:0]  ns_a, ew_a, ns_b, ew_b;
   logic        walk_a, walk_b;
   logic [2:0]  state_a, state_b;
   logic        dn_a, dn_b;
   logic [31:0] cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;

   traffic_light_ctrl #(
      .T_GREEN(32'd4), .T_YELLOW(32'd2), .T_ALLRED(32'd1), .T_WALK(32'd3)
   ) dut_a (
      .clk(clk), .reset(reset), .dn(dn_a), .ped_req(ped_req),
      .cnt_len(cnt_len_a), .cnt_rst(cnt_rst_a), .ns_light(ns_a), .ew_light(ew_a),
      .walk(walk_a), .state(state_a)
   );

   traffic_light_ctrl #(
      .T_GREEN(32'd4), .T_YELLOW(32'd0), .T_ALLRED(32'd1), .T_WALK(32'd3)
   ) dut_b (
      .clk(clk), .reset(reset), .dn(dn_b), .ped_req(ped_req),
      .cnt_len(cnt_len_b), .cnt_rst(cnt_rst_b), .ns_light(ns_b), .ew_light(ew_b),
      .walk(walk_b), .state(state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Delay counter: dn pulses once every len+1 edges while its reset is low.
   always @(posedge clk) begin
      if (cnt_rst_a) begin
         cnt_a <= 32'd0; dn_a <= 1'b0;
      end else if (cnt_a == cnt_len_a) begin
         cnt_a <= 32'd0; dn_a <= 1'b1;
      end else begin
         cnt_a <= cnt_a + 32'd1; dn_a <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (cnt_rst_b) begin
         cnt_b <= 32'd0; dn_b <= 1'b0;
      end else if (cnt_b == cnt_len_b) begin
         cnt_b <= 32'd0; dn_b <= 1'b1;
      end else begin
         cnt_b <= cnt_b + 32'd1; dn_b <= 1'b0;
      end
   end

   // Lamp safety on every cycle: one-hot per road, at least one road red, walk only with all red.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (!$onehot(ns_a) || !$onehot(ew_a) || !(ns_a[2] || ew_a[2]) ||
             (walk_a && (ns_a !== 3'b100 || ew_a !== 3'b100)) || state_a > 3'd6) begin
            errors++;
            $display("FAIL lamp_rules_a: state=%0d ns=%b ew=%b walk=%b", state_a, ns_a, ew_a, walk_a);
         end
         checks++;
         if (!$onehot(ns_b) || !$onehot(ew_b) || !(ns_b[2] || ew_b[2]) ||
             (walk_b && (ns_b !== 3'b100 || ew_b !== 3'b100)) || state_b > 3'd6) begin
            errors++;
            $display("FAIL lamp_rules_b: state=%0d ns=%b ew=%b walk=%b", state_b, ns_b, ew_b, walk_b);
         end
      end
   end

   function automatic logic [2:0] exp_ns(input int s);
      case (s)
         0:       exp_ns = 3'b001;
         1:       exp_ns = 3'b010;
         default: exp_ns = 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_ew(input int s);
      case (s)
         3:       exp_ew = 3'b001;
         4:       exp_ew = 3'b010;
         default: exp_ew = 3'b100;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
   endtask

   // Edges until the selected instance changes state, capped at 200.
   task automatic wait_change(input bit sel, output int n);
      logic [2:0] prev;
      prev = sel ? state_b : state_a;
      n = 0;
      do begin
         step();
         n++;
      end while (((sel ? state_b : state_a) == prev) && n < 200);
   endtask

   task automatic test_reset();
      ped_req = 1'b0;
      reset   = 1'b1;
      repeat (3) step();
      mon_en = 1'b1;
      checks++;
      if (state_a !== 3'd0 || ns_a !== 3'b001 || ew_a !== 3'b100 || walk_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_lamps: state=%0d ns=%b ew=%b walk=%b, expected 0 001 100 0",
                  state_a, ns_a, ew_a, walk_a);
      end
      checks++;
      if (cnt_rst_a !== 1'b1 || cnt_len_a !== 32'd4) begin
         errors++;
         $display("FAIL reset_counter: cnt_rst=%b cnt_len=%0d, expected 1 4", cnt_rst_a, cnt_len_a);
      end
      reset = 1'b0;
      step();
      checks++;
      if (cnt_rst_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_cnt_rst: got %b, expected 0", cnt_rst_a);
      end
      repeat (5) step();
      checks++;
      if (ns_a !== 3'b001) begin
         errors++;
         $display("FAIL reset_edge6_ns: got %b, expected 001", ns_a);
      end
      step();
      checks++;
      if (ns_a !== 3'b010 || state_a !== 3'd1) begin
         errors++;
         $display("FAIL reset_edge7_ns: ns=%b state=%0d, expected 010 1", ns_a, state_a);
      end
   endtask

   task automatic test_nominal();
      int exp_st[6] = '{1, 2, 3, 4, 5, 0};
      int exp_dw[6] = '{7, 5, 4, 7, 5, 4};
      int n;
      int total;
      ped_req = 1'b0;
      apply_reset();
      total = 0;
      for (int i = 0; i < 6; i++) begin
         wait_change(1'b0, n);
         total += n;
         checks++;
         if (n !== exp_dw[i] || state_a !== 3'(exp_st[i])) begin
            errors++;
            $display("FAIL nominal_phase%0d: dwell=%0d state=%0d, expected dwell=%0d state=%0d",
                     i, n, state_a, exp_dw[i], exp_st[i]);
         end
         checks++;
         if (ns_a !== exp_ns(exp_st[i]) || ew_a !== exp_ew(exp_st[i]) || walk_a !== 1'b0) begin
            errors++;
            $display("FAIL nominal_lamps%0d: ns=%b ew=%b walk=%b, expected %b %b 0",
                     i, ns_a, ew_a, walk_a, exp_ns(exp_st[i]), exp_ew(exp_st[i]));
         end
      end
      checks++;
      if (total !== 32) begin
         errors++;
         $display("FAIL nominal_period: got %0d cycles, expected 32", total);
      end
   endtask

   task automatic test_single_request();
      int exp_st[7] = '{1, 2, 6, 3, 4, 5, 0};
      int exp_dw[7] = '{4, 5, 4, 6, 7, 5, 4};
      int n;
      ped_req = 1'b0;
      apply_reset();
      repeat (2) step();
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wait_change(1'b0, n);
         checks++;
         if (n !== exp_dw[i] || state_a !== 3'(exp_st[i])) begin
            errors++;
            $display("FAIL single_phase%0d: dwell=%0d state=%0d, expected dwell=%0d state=%0d",
                     i, n, state_a, exp_dw[i], exp_st[i]);
         end
         checks++;
         if (ns_a !== exp_ns(exp_st[i]) || ew_a !== exp_ew(exp_st[i]) ||
             walk_a !== (exp_st[i] == 6)) begin
            errors++;
            $display("FAIL single_lamps%0d: ns=%b ew=%b walk=%b, expected %b %b %0d",
                     i, ns_a, ew_a, walk_a, exp_ns(exp_st[i]), exp_ew(exp_st[i]), exp_st[i] == 6);
         end
      end
   endtask

   task automatic test_held_request();
      int exp_st[8] = '{1, 2, 6, 3, 4, 5, 6, 0};
      int exp_dw[8] = '{7, 5, 4, 6, 7, 5, 4, 6};
      int n;
      int carry;
      ped_req = 1'b1;
      apply_reset();
      carry = 0;
      for (int i = 0; i < 8; i++) begin
         wait_change(1'b0, n);
         n += carry;
         carry = 0;
         checks++;
         if (n !== exp_dw[i] || state_a !== 3'(exp_st[i])) begin
            errors++;
            $display("FAIL held_phase%0d: dwell=%0d state=%0d, expected dwell=%0d state=%0d",
                     i, n, state_a, exp_dw[i], exp_st[i]);
         end
         if (state_a == 3'd6) begin
            checks++;
            if (dut_a.ped_pend_q !== 1'b0) begin
               errors++;
               $display("FAIL held_pend_clear%0d: got %b, expected 0", i, dut_a.ped_pend_q);
            end
            step();
            carry = 1;
            checks++;
            if (dut_a.ped_pend_q !== 1'b1) begin
               errors++;
               $display("FAIL held_pend_relatch%0d: got %b, expected 1", i, dut_a.ped_pend_q);
            end
         end
      end
      ped_req = 1'b0;
   endtask

   task automatic test_zero_len();
      int exp_st[6] = '{1, 2, 3, 4, 5, 0};
      int exp_dw[6] = '{7, 3, 4, 7, 3, 4};
      int n;
      ped_req = 1'b0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         wait_change(1'b1, n);
         checks++;
         if (n !== exp_dw[i] || state_b !== 3'(exp_st[i])) begin
            errors++;
            $display("FAIL zero_phase%0d: dwell=%0d state=%0d, expected dwell=%0d state=%0d",
                     i, n, state_b, exp_dw[i], exp_st[i]);
         end
      end
   endtask

   task automatic test_reset_mid_walk();
      int exp_st[3] = '{1, 2, 3};
      int exp_dw[3] = '{7, 5, 4};
      int n;
      int hops;
      ped_req = 1'b0;
      apply_reset();
      step();
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      hops = 0;
      while (state_a != 3'd6 && hops < 10) begin
         wait_change(1'b0, n);
         hops++;
      end
      checks++;
      if (state_a !== 3'd6) begin
         errors++;
         $display("FAIL midwalk_reach: state=%0d, expected 6", state_a);
      end
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      checks++;
      if (dut_a.ped_pend_q !== 1'b1) begin
         errors++;
         $display("FAIL midwalk_pend_set: got %b, expected 1", dut_a.ped_pend_q);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (state_a !== 3'd0 || cnt_rst_a !== 1'b1 || dut_a.ped_pend_q !== 1'b0 ||
          walk_a !== 1'b0 || ns_a !== 3'b001 || ew_a !== 3'b100 || cnt_len_a !== 32'd4) begin
         errors++;
         $display("FAIL midwalk_reset: state=%0d cnt_rst=%b pend=%b walk=%b ns=%b ew=%b len=%0d, expected 0 1 0 0 001 100 4",
                  state_a, cnt_rst_a, dut_a.ped_pend_q, walk_a, ns_a, ew_a, cnt_len_a);
      end
      for (int i = 0; i < 3; i++) begin
         wait_change(1'b0, n);
         checks++;
         if (n !== exp_dw[i] || state_a !== 3'(exp_st[i])) begin
            errors++;
            $display("FAIL midwalk_resume%0d: dwell=%0d state=%0d, expected dwell=%0d state=%0d",
                     i, n, state_a, exp_dw[i], exp_st[i]);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      ped_req = 1'b0;
      test_reset();
      test_nominal();
      test_single_request();
      test_held_request();
      test_zero_len();
      test_reset_mid_walk();
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
